// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and framing-error detection
module uart_receiver #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;

    // Synchroniser flops reset high so a released reset does not look like a start edge
    // unless the line really is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pulses are raised only on the stop-bit sample, so they can never repeat back to back.
    always_comb begin
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        busy        = (state_q != S_IDLE);
        if (state_q == S_STOP && cnt_q == CNT_LAST) begin
            if (rx_s_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed bench for uart_receiver at a reduced 16 clocks per bit
module tb_uart_receiver;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT      = 2 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         start_cyc = 0;
    int         last_valid_cyc = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] rx_log [0:63];

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DATA_BITS(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: logs bytes and checks pulses never overlap or repeat on adjacent cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid || frame_err) begin
                checks++;
                assert (!(valid && frame_err) && !prev_pulse) else begin
                    errors++;
                    $error("FAIL pulse_excl: valid=%0b frame_err=%0b prev=%0b expected isolated single pulse",
                           valid, frame_err, prev_pulse);
                end
            end
            if (valid) begin
                rx_log[vcnt[5:0]] = data;
                vcnt++;
                last_valid_cyc = cyc;
            end
            if (frame_err) fcnt++;
            prev_pulse = valid || frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    int v0, f0, bcyc, lat;
    logic [7:0] d0;

    initial begin
        tick(4);
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(4);

        // 1: single good byte and its latency
        v0 = vcnt; f0 = fcnt;
        send_byte(8'hA5, 1'b1);
        tick(CPB);
        chk("t1_vcnt", vcnt, v0 + 1);
        chk("t1_data", {24'd0, data}, 32'hA5);
        chk("t1_log", {24'd0, rx_log[v0[5:0]]}, 32'hA5);
        chk("t1_ferr", fcnt, f0);
        lat = last_valid_cyc - start_cyc;
        chk("t1_latency", {31'd0, (lat >= LAT - 1 && lat <= LAT + 2)}, 32'd1);

        // 2: short glitch is rejected shortly after half a bit
        v0 = vcnt; f0 = fcnt; bcyc = 0;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
        end
        tick(1);
        chk("t2_busy_seen", {31'd0, (bcyc > 0)}, 32'd1);
        chk("t2_busy_len", {31'd0, (bcyc <= HALF + 1)}, 32'd1);
        chk("t2_idle", {31'd0, busy}, 32'd0);
        chk("t2_vcnt", vcnt, v0);
        chk("t2_ferr", fcnt, f0);

        // 3: bad stop bit, data held, then a good byte
        v0 = vcnt; f0 = fcnt; d0 = data;
        send_byte(8'h3C, 1'b0);
        tick(2 * CPB);
        chk("t3_ferr", fcnt, f0 + 1);
        chk("t3_vcnt", vcnt, v0);
        chk("t3_data_kept", {24'd0, data}, {24'd0, d0});
        send_byte(8'h81, 1'b1);
        tick(CPB);
        chk("t3_vcnt2", vcnt, v0 + 1);
        chk("t3_data2", {24'd0, data}, 32'h81);

        // 4: back-to-back frames with no idle gap
        v0 = vcnt; f0 = fcnt;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        tick(CPB);
        chk("t4_vcnt", vcnt, v0 + 2);
        chk("t4_first", {24'd0, rx_log[v0[5:0]]}, 32'h00);
        chk("t4_second", {24'd0, rx_log[(v0 + 1) & 63]}, 32'hFF);
        chk("t4_ferr", fcnt, f0);

        // 5: long break yields one framing error only
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        tick(30 * CPB);
        chk("t5_busy_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        tick(2 * CPB);
        chk("t5_ferr", fcnt, f0 + 1);
        chk("t5_vcnt", vcnt, v0);
        send_byte(8'h55, 1'b1);
        tick(CPB);
        chk("t5_vcnt2", vcnt, v0 + 1);
        chk("t5_data", {24'd0, data}, 32'h55);

        // 6: reset during bit 4 of 0xF0 aborts the frame
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hF0 >> i) & 8'h01;
            tick(CPB);
        end
        rx = 1'b1;
        tick(HALF);
        rst = 1'b1;
        tick(2);
        chk("t6_data", {24'd0, data}, 32'h00);
        chk("t6_valid", {31'd0, valid}, 32'd0);
        chk("t6_ferr_o", {31'd0, frame_err}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(6 * CPB);
        chk("t6_no_pulse_v", vcnt, v0);
        chk("t6_no_pulse_f", fcnt, f0);
        chk("t6_idle", {31'd0, busy}, 32'd0);
        send_byte(8'h0F, 1'b1);
        tick(CPB);
        chk("t6_vcnt", vcnt, v0 + 1);
        chk("t6_rx", {24'd0, data}, 32'h0F);
        chk("t6_ferr", fcnt, f0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
